// File: rtl/row_select_sequencer.sv
// row_select_sequencer: registered ADDR_W-to-2^ADDR_W active-low row decoder
// with timed select pulses, guaranteed all-high gaps between rows, and
// multi-row bursts that auto-increment and wrap the row address.
module row_select_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req,
  input  logic [ADDR_W-1:0]        start_addr,
  input  logic [ADDR_W:0]          burst_len,
  input  logic                     abort,
  output logic [(1<<ADDR_W)-1:0]   sel_n,
  output logic [ADDR_W-1:0]        cur_addr,
  output logic                     busy,
  output logic                     done
);

  localparam int ROWS    = 1 << ADDR_W;
  localparam int CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [ADDR_W:0]   ROWS_L  = (ADDR_W+1)'(ROWS);
  localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
  localparam logic [CNT_W-1:0]  PULSE_L = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0]  GAP_L   = CNT_W'(GAP_W);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [ROWS-1:0]   ROW_ONE = ROWS'(1);

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;     // shared pulse/gap phase counter
  logic [ADDR_W:0]    rows_q, rows_d;   // rows still to be selected
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ROWS-1:0]    sel_n_q, sel_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ADDR_W:0]    eff_len;

  // Effective burst length: 0 means one row, anything beyond the array size
  // is clamped to a single full sweep.
  always_comb begin
    eff_len = burst_len;
    if (burst_len == '0)         eff_len = LEN_ONE;
    else if (burst_len > ROWS_L) eff_len = ROWS_L;
  end

  // Next-state and registered-output decode; outputs are computed from the
  // next state so sel_n/busy/done come straight off flops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rows_d  = rows_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !abort) begin
          addr_d  = start_addr;
          rows_d  = eff_len;
          cnt_d   = PULSE_L;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_ONE) begin
          cnt_d   = GAP_L;
          rows_d  = rows_q - LEN_ONE;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_ONE) begin
          if (rows_q != '0) begin
            addr_d  = addr_q + ADDR_W'(1);   // wraps naturally at 2^ADDR_W
            cnt_d   = PULSE_L;
            state_d = ACTIVE;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    sel_n_d = (state_d == ACTIVE) ? ~(ROW_ONE << addr_d) : '1;
  end

  // State and output registers; reset forces every select high at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rows_q  <= '0;
      addr_q  <= '0;
      sel_n_q <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rows_q  <= rows_d;
      addr_q  <= addr_d;
      sel_n_q <= sel_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sel_n    = sel_n_q;
  assign cur_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_row_select_sequencer.sv
// Bench for row_select_sequencer: a driver turns each accepted request into a
// per-cycle expected trace (queue), and a monitor pops and compares it.
module tb_row_select_sequencer;
  localparam int ADDR_W  = 4;
  localparam int PULSE_W = 2;
  localparam int GAP_W   = 1;
  localparam int ROWS    = 1 << ADDR_W;

  typedef struct {
    int                cyc;
    logic [ROWS-1:0]   sel;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  logic              clk, rst_n, req, abort;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   burst_len;
  logic [ROWS-1:0]   sel_n;
  logic [ADDR_W-1:0] cur_addr;
  logic              busy, done;

  exp_t              exp_q[$];
  logic [ADDR_W-1:0] idle_addr;
  int                cyc = 0;
  int                checks = 0;
  int                errors = 0;

  row_select_sequencer #(.ADDR_W(ADDR_W), .PULSE_W(PULSE_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .start_addr(start_addr),
    .burst_len(burst_len), .abort(abort), .sel_n(sel_n),
    .cur_addr(cur_addr), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  // Reference: an accepted operation is N rows, each PULSE_W low cycles then
  // GAP_W all-high cycles, followed by one done cycle.
  function automatic int push_op(int first, logic [ADDR_W-1:0] sa, int bl);
    int n;
    int c;
    exp_t e;
    logic [ADDR_W-1:0] a;
    n = (bl == 0) ? 1 : ((bl > ROWS) ? ROWS : bl);
    c = first;
    a = sa;
    for (int i = 0; i < n; i++) begin
      a = ADDR_W'((int'(sa) + i) % ROWS);
      for (int k = 0; k < PULSE_W + GAP_W; k++) begin
        e.cyc = c; e.sel = '1; if (k < PULSE_W) e.sel[a] = 1'b0;
        e.busy = 1'b1; e.done = 1'b0; e.addr = a;
        exp_q.push_back(e);
        c++;
      end
    end
    e.cyc = c; e.sel = '1; e.busy = 1'b0; e.done = 1'b1; e.addr = a;
    exp_q.push_back(e);
    return c;
  endfunction

  // One cycle of stimulus; inputs change just after the rising edge.
  task automatic drive(logic r, logic [ADDR_W-1:0] sa, logic [ADDR_W:0] bl,
                       logic ab, output int done_cyc);
    @(posedge clk); #1;
    req = r; start_addr = sa; burst_len = bl; abort = ab;
    done_cyc = -1;
    if (ab)
      while (exp_q.size() > 0 && exp_q[$].cyc >= cyc + 1) void'(exp_q.pop_back());
    if (r && !ab && (exp_q.size() == 0 || exp_q[$].cyc <= cyc))
      done_cyc = push_op(cyc + 1, sa, int'(bl));
  endtask

  task automatic idle_cycle();
    int d;
    drive(1'b0, ADDR_W'($urandom), (ADDR_W+1)'($urandom), 1'b0, d);
  endtask

  task automatic wait_until(int t);
    int guard = 0;
    while (cyc < t && guard < 5000) begin idle_cycle(); guard++; end
    if (cyc < t) begin
      errors++; checks++;
      $display("FAIL wait_timeout: cycle %0d target %0d", cyc, t);
    end
  endtask

  // Monitor: compare every cycle against the expected trace, or against the
  // idle response when nothing is scheduled; also track the select invariants.
  exp_t me;
  int   cur_low, prev_low, ones_run;
  bit   had_low;
  always @(negedge clk) begin
    if (!rst_n) begin
      had_low = 1'b0; prev_low = -1; ones_run = 0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        errors++; checks++;
        $display("FAIL stale_entry: entry cycle %0d now %0d", exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        me = exp_q.pop_front();
        idle_addr = me.addr;
      end else begin
        me.cyc = cyc; me.sel = '1; me.busy = 1'b0; me.done = 1'b0; me.addr = idle_addr;
      end
      chk("sel_n", 64'(sel_n), 64'(me.sel));
      chk("busy", 64'(busy), 64'(me.busy));
      chk("done", 64'(done), 64'(me.done));
      chk("cur_addr", 64'(cur_addr), 64'(me.addr));
      chk("at_most_one_low", 64'($countones(~sel_n) <= 1), 64'(1));
      cur_low = -1;
      for (int b = 0; b < ROWS; b++) if (!sel_n[b]) cur_low = b;
      if (cur_low >= 0) begin
        if (prev_low >= 0) chk("bbm_adjacent_rows", 64'(cur_low), 64'(prev_low));
        else if (had_low) chk("bbm_gap_len_ok", 64'(ones_run >= GAP_W), 64'(1));
        had_low = 1'b1; ones_run = 0;
      end else begin
        ones_run++;
      end
      prev_low = cur_low;
    end
  end

  initial begin
    int d, d2, t0, hold;
    logic r, ab;
    rst_n = 1'b0; req = 1'b0; abort = 1'b0; start_addr = '0; burst_len = '0;
    idle_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel_n", 64'(sel_n), 64'hFFFF);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_cur_addr", 64'(cur_addr), 64'(0));
    #3 rst_n = 1'b1;
    repeat (2) idle_cycle();

    // single row
    drive(1'b1, 4'd5, 5'd1, 1'b0, d); wait_until(d); idle_cycle();
    // wrapping burst 14,15,0,1
    drive(1'b1, 4'd14, 5'd4, 1'b0, d); wait_until(d); idle_cycle();
    // length edge cases
    drive(1'b1, 4'd7, 5'd0, 1'b0, d); wait_until(d); idle_cycle();
    drive(1'b1, 4'd3, 5'd16, 1'b0, d); wait_until(d); idle_cycle();
    drive(1'b1, 4'd3, 5'd31, 1'b0, d); wait_until(d); idle_cycle();

    // abort at the second ACTIVE cycle of the second row
    drive(1'b1, 4'd6, 5'd4, 1'b0, d); t0 = cyc;
    wait_until(t0 + PULSE_W + GAP_W + 1);
    drive(1'b0, 4'd0, 5'd0, 1'b1, d2);
    repeat (4) idle_cycle();

    // req together with abort in IDLE
    drive(1'b1, 4'd9, 5'd2, 1'b1, d2);
    repeat (4) idle_cycle();

    // req during GAP is ignored
    drive(1'b1, 4'd2, 5'd2, 1'b0, d); t0 = cyc;
    wait_until(t0 + PULSE_W);
    drive(1'b1, 4'd11, 5'd1, 1'b0, d2);
    wait_until(d); idle_cycle();

    // back-to-back: second req in the done cycle
    drive(1'b1, 4'd15, 5'd1, 1'b0, d); wait_until(d - 1);
    drive(1'b1, 4'd0, 5'd2, 1'b0, d2); wait_until(d2); idle_cycle();

    // asynchronous reset in the middle of an ACTIVE pulse
    drive(1'b1, 4'd9, 5'd3, 1'b0, d);
    idle_cycle();
    #1 rst_n = 1'b0;
    exp_q.delete(); idle_addr = '0;
    #1;
    chk("arst_sel_n", 64'(sel_n), 64'hFFFF);
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_cur_addr", 64'(cur_addr), 64'(0));
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (6) idle_cycle();

    // randomized traffic
    hold = 0;
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 3) == 0);
      ab = (hold == 0) && ($urandom_range(0, 24) == 0);
      if (hold > 0) begin r = 1'b0; hold--; end
      drive(r, ADDR_W'($urandom), (ADDR_W+1)'($urandom_range(0, 31)), ab, d);
      if (ab) hold = GAP_W;
    end
    drive(1'b0, '0, '0, 1'b0, d);
    if (exp_q.size() > 0) wait_until(exp_q[$].cyc + 1);
    repeat (2) idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
